// File: rtl/qnigma_add_seq.sv
`timescale 1ns/1ps
// qnigma_add_seq
// Sequential multi-limb adder/subtractor. One operation reads N limbs of a and
// b from an external limb memory, least significant limb first, and streams
// back N result limbs with a ripple carry kept in a register.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start, sub, cin    request (IDLE only), 0=a+b / 1=a-b, add carry-in
//   rd_en, rd_idx      limb read strobe and index; data returns one cycle later
//   a_dat, b_dat       limb of a / b, valid the cycle after rd_en
//   q_vld, q_idx,q_dat result limb strobe, index, value
//   busy, done         not-IDLE flag, one-cycle completion pulse
//   cout, zero         final carry (add) or no-borrow (sub), all-zero result
//
// Timing, start accepted at cycle 0: rd_en cycles 1..N, data cycles 2..N+1,
// q_vld cycles 3..N+2, done at cycle N+2, next accept at cycle N+3.
module qnigma_add_seq #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic                 cin,
  output logic                 rd_en,
  output logic [$clog2(N)-1:0] rd_idx,
  input  logic [W-1:0]         a_dat,
  input  logic [W-1:0]         b_dat,
  output logic                 q_vld,
  output logic [$clog2(N)-1:0] q_idx,
  output logic [W-1:0]         q_dat,
  output logic                 busy,
  output logic                 done,
  output logic                 cout,
  output logic                 zero
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, FLUSH} state_t;

  // One limb of a + b' + carry, b' inverted for subtraction (two's complement
  // via the carry register being seeded with 1).
  function automatic logic [W:0] limb_sum(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         do_sub,
                                          input logic         c);
    logic [W-1:0] bx;
    bx = do_sub ? ~b : b;
    return {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c};
  endfunction

  state_t          state;
  logic            sub_q;
  logic            carry;
  logic            nz_acc;   // set once any result limb of this operation is nonzero
  logic            vld_p1;   // a_dat/b_dat valid this cycle
  logic [IW-1:0]   idx_p1;   // limb index belonging to a_dat/b_dat
  logic [W:0]      sum_p1;

  assign sum_p1 = limb_sum(a_dat, b_dat, sub_q, carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      nz_acc <= 1'b0;
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      rd_en  <= 1'b0;
      rd_idx <= '0;
      q_vld  <= 1'b0;
      q_idx  <= '0;
      q_dat  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else begin
      // Read request -> memory data stage
      vld_p1 <= rd_en;
      idx_p1 <= rd_idx;
      q_vld  <= 1'b0;
      done   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state  <= READ;
            busy   <= 1'b1;
            sub_q  <= sub;
            carry  <= sub ? 1'b1 : cin;
            nz_acc <= 1'b0;
            rd_en  <= 1'b1;
            rd_idx <= '0;
          end
        end
        READ: begin
          if (rd_idx == LAST) begin
            state  <= WAIT;
            rd_en  <= 1'b0;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + IW'(1);
          end
        end
        WAIT:  state <= FLUSH;
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Data stage -> result stage
      if (vld_p1) begin
        q_vld  <= 1'b1;
        q_dat  <= sum_p1[W-1:0];
        q_idx  <= idx_p1;
        carry  <= sum_p1[W];
        nz_acc <= nz_acc | (|sum_p1[W-1:0]);
        if (idx_p1 == LAST) begin
          done <= 1'b1;
          cout <= sum_p1[W];
          zero <= ~(nz_acc | (|sum_p1[W-1:0]));
        end
      end
    end
  end

endmodule
